// File: rtl/forwarding_unit_pkg.sv
// Shared pipeline constants for the forwarding unit: register-address width
// and ALU bypass mux select encodings. Operand A and operand B use different encodings.
package forwarding_unit_pkg;
  localparam int REG_AW = 5;

  localparam logic [1:0] FWDA_RF    = 2'b00;
  localparam logic [1:0] FWDA_EXMEM = 2'b10;
  localparam logic [1:0] FWDA_MEMWB = 2'b01;

  localparam logic [1:0] FWDB_RF    = 2'b00;
  localparam logic [1:0] FWDB_EXMEM = 2'b01;
  localparam logic [1:0] FWDB_MEMWB = 2'b10;
endpackage

// File: rtl/fwd_operand_select.sv
// Bypass select for one ALU source register. EX/MEM takes priority over MEM/WB.
// Each instance is given its own output codes.
module fwd_operand_select #(
  parameter int         REG_AW     = 5,
  parameter logic [1:0] RF_CODE    = 2'b00,
  parameter logic [1:0] EXMEM_CODE = 2'b10,
  parameter logic [1:0] MEMWB_CODE = 2'b01
) (
  input  logic [REG_AW-1:0] srcReg,
  input  logic [REG_AW-1:0] exmemRd,
  input  logic [REG_AW-1:0] memwbRd,
  input  logic              exmemRegWrite,
  input  logic              memwbRegWrite,
  output logic [1:0]        fwdSel
);
  logic exHit, memHit;

  // r0 is hard-wired zero, so a write to it is never a real producer.
  assign exHit  = exmemRegWrite && (exmemRd != '0) && (exmemRd == srcReg);
  assign memHit = memwbRegWrite && (memwbRd != '0) && (memwbRd == srcReg);

  always_comb begin
    fwdSel = RF_CODE;
    if (exHit)       fwdSel = EXMEM_CODE;
    else if (memHit) fwdSel = MEMWB_CODE;
  end
endmodule

// File: rtl/forwarding_unit.sv
// Data-hazard forwarding control: ALU operand bypass selects and load->store data bypass,
// plus a saturating count of cycles in which any bypass is active.
module forwarding_unit #(
  parameter int REG_AW = forwarding_unit_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [REG_AW-1:0] IDEX_rs,
  input  logic [REG_AW-1:0] IDEX_rt,
  input  logic [REG_AW-1:0] EXMEM_rd,
  input  logic [REG_AW-1:0] MEMWB_rd,
  input  logic              EXMEM_regWrite,
  input  logic              MEMWB_regWrite,
  input  logic              MEMWB_MemtoReg,
  input  logic              EXMEM_MemWrite,
  output logic [1:0]        fwdSignalA,
  output logic [1:0]        fwdSignalB,
  output logic              fwdSignalC,
  output logic [CNT_W-1:0]  fwdEventCount
);
  import forwarding_unit_pkg::*;

  logic [1:0] selA, selB;
  logic       selC, anyFwd;

  fwd_operand_select #(
    .REG_AW(REG_AW), .RF_CODE(FWDA_RF), .EXMEM_CODE(FWDA_EXMEM), .MEMWB_CODE(FWDA_MEMWB)
  ) u_selA (
    .srcReg(IDEX_rs), .exmemRd(EXMEM_rd), .memwbRd(MEMWB_rd),
    .exmemRegWrite(EXMEM_regWrite), .memwbRegWrite(MEMWB_regWrite), .fwdSel(selA)
  );

  fwd_operand_select #(
    .REG_AW(REG_AW), .RF_CODE(FWDB_RF), .EXMEM_CODE(FWDB_EXMEM), .MEMWB_CODE(FWDB_MEMWB)
  ) u_selB (
    .srcReg(IDEX_rt), .exmemRd(EXMEM_rd), .memwbRd(MEMWB_rd),
    .exmemRegWrite(EXMEM_regWrite), .memwbRegWrite(MEMWB_regWrite), .fwdSel(selB)
  );

  // A load in WB feeding the store in MEM: bypass the loaded word to the store data.
  assign selC = MEMWB_regWrite && MEMWB_MemtoReg && EXMEM_MemWrite &&
                (MEMWB_rd != '0) && (MEMWB_rd == EXMEM_rd);

  // Reset masks the selects asynchronously; release takes effect immediately.
  assign fwdSignalA = Reset_n ? selA : FWDA_RF;
  assign fwdSignalB = Reset_n ? selB : FWDB_RF;
  assign fwdSignalC = Reset_n && selC;

  assign anyFwd = (fwdSignalA != 2'b00) || (fwdSignalB != 2'b00) || fwdSignalC;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                          fwdEventCount <= '0;
    else if (anyFwd && (~fwdEventCount != '0)) fwdEventCount <= fwdEventCount + 1'b1;
  end
endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed vector table, reset/saturation sequences,
// and randomized traffic against a rule-level reference model.
module tb_forwarding_unit;
  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [4:0] IDEX_rs = '0, IDEX_rt = '0, EXMEM_rd = '0, MEMWB_rd = '0;
  logic       EXMEM_regWrite = 1'b0, MEMWB_regWrite = 1'b0, MEMWB_MemtoReg = 1'b0, EXMEM_MemWrite = 1'b0;
  logic [1:0] fwdSignalA, fwdSignalB, satA, satB;
  logic       fwdSignalC, satC;
  logic [15:0] fwdEventCount;
  logic [1:0]  satCount;

  always #5 Clock = ~Clock;

  forwarding_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt),
    .EXMEM_rd(EXMEM_rd), .MEMWB_rd(MEMWB_rd), .EXMEM_regWrite(EXMEM_regWrite),
    .MEMWB_regWrite(MEMWB_regWrite), .MEMWB_MemtoReg(MEMWB_MemtoReg), .EXMEM_MemWrite(EXMEM_MemWrite),
    .fwdSignalA(fwdSignalA), .fwdSignalB(fwdSignalB), .fwdSignalC(fwdSignalC), .fwdEventCount(fwdEventCount)
  );

  forwarding_unit #(.REG_AW(5), .CNT_W(2)) u_sat (
    .Clock(Clock), .Reset_n(Reset_n), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt),
    .EXMEM_rd(EXMEM_rd), .MEMWB_rd(MEMWB_rd), .EXMEM_regWrite(EXMEM_regWrite),
    .MEMWB_regWrite(MEMWB_regWrite), .MEMWB_MemtoReg(MEMWB_MemtoReg), .EXMEM_MemWrite(EXMEM_MemWrite),
    .fwdSignalA(satA), .fwdSignalB(satB), .fwdSignalC(satC), .fwdEventCount(satCount)
  );

  typedef struct {
    logic [4:0] rs, rt, exRd, memRd;
    logic       exRw, memRw, m2r, mw;
    logic [1:0] eA, eB;
    logic       eC;
  } vec_t;

  int nVec = 0, nBad = 0;
  int refCnt = 0, refSat = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    IDEX_rs = v.rs; IDEX_rt = v.rt; EXMEM_rd = v.exRd; MEMWB_rd = v.memRd;
    EXMEM_regWrite = v.exRw; MEMWB_regWrite = v.memRw;
    MEMWB_MemtoReg = v.m2r; EXMEM_MemWrite = v.mw;
  endtask

  // Reference: which stage (if any) supplies the register, 0 = none, 1 = EX/MEM, 2 = MEM/WB.
  function automatic int srcStage(input vec_t v, input logic [4:0] r);
    if (r == 0) return 0;
    if (v.exRw && v.exRd == r) return 1;
    if (v.memRw && v.memRd == r) return 2;
    return 0;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int sa = srcStage(v, v.rs), sb = srcStage(v, v.rt);
    o.eA = (sa == 1) ? 2'd2 : (sa == 2) ? 2'd1 : 2'd0;
    o.eB = (sb == 1) ? 2'd1 : (sb == 2) ? 2'd2 : 2'd0;
    o.eC = v.memRw && v.m2r && v.mw && (v.memRd != 0) && (v.memRd == v.exRd);
    return o;
  endfunction

  function automatic vec_t mk(input int rs, rt, exRd, memRd, exRw, memRw, m2r, mw);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.exRd = 5'(exRd); v.memRd = 5'(memRd);
    v.exRw = 1'(exRw); v.memRw = 1'(memRw); v.m2r = 1'(m2r); v.mw = 1'(mw);
    v.eA = 2'd0; v.eB = 2'd0; v.eC = 1'b0;
    return v;
  endfunction

  task automatic checkSel(input string tag, input vec_t v);
    chk({tag, ".A"}, int'(fwdSignalA), int'(v.eA));
    chk({tag, ".B"}, int'(fwdSignalB), int'(v.eB));
    chk({tag, ".C"}, int'(fwdSignalC), int'(v.eC));
  endtask

  // Apply a vector just after an edge, check selects, clock once, check both counters.
  task automatic step(input string tag, input vec_t v, input bit checkSelects);
    vec_t m;
    drive(v);
    #1;
    m = model(v);
    if (checkSelects) checkSel(tag, v);
    @(posedge Clock);
    if (m.eA != 0 || m.eB != 0 || m.eC) begin
      if (refCnt < 65535) refCnt++;
      if (refSat < 3) refSat++;
    end
    #1;
    chk({tag, ".cnt"}, int'(fwdEventCount), refCnt);
    chk({tag, ".sat"}, int'(satCount), refSat);
  endtask

  task automatic doReset();
    @(posedge Clock); #2;
    Reset_n = 1'b0;
    refCnt = 0; refSat = 0;
    #1;
    chk("rst.cnt", int'(fwdEventCount), 0);
    chk("rst.sat", int'(satCount), 0);
    #1 Reset_n = 1'b1;
  endtask

  vec_t tbl[8];
  vec_t c1, v;

  initial begin
    tbl[0] = mk(1, 1, 1, 1, 1, 1, 1, 1); tbl[0].eA = 2'b10; tbl[0].eB = 2'b01; tbl[0].eC = 1'b1;
    tbl[1] = mk(1, 1, 1, 1, 0, 0, 1, 1); tbl[1].eA = 2'b00; tbl[1].eB = 2'b00; tbl[1].eC = 1'b0;
    tbl[2] = mk(1, 1, 3, 1, 1, 1, 0, 0); tbl[2].eA = 2'b01; tbl[2].eB = 2'b10; tbl[2].eC = 1'b0;
    tbl[3] = mk(0, 0, 0, 0, 1, 1, 1, 1); tbl[3].eA = 2'b00; tbl[3].eB = 2'b00; tbl[3].eC = 1'b0;
    tbl[4] = mk(2, 5, 5, 2, 1, 1, 0, 0); tbl[4].eA = 2'b01; tbl[4].eB = 2'b01; tbl[4].eC = 1'b0;
    tbl[5] = mk(7, 9, 4, 4, 0, 1, 1, 1); tbl[5].eA = 2'b00; tbl[5].eB = 2'b00; tbl[5].eC = 1'b1;
    tbl[6] = mk(7, 9, 4, 6, 1, 1, 1, 1); tbl[6].eA = 2'b00; tbl[6].eB = 2'b00; tbl[6].eC = 1'b0;
    tbl[7] = mk(31, 31, 31, 31, 1, 1, 1, 0); tbl[7].eA = 2'b10; tbl[7].eB = 2'b01; tbl[7].eC = 1'b0;
    c1 = tbl[0];

    // Reset asserted with full forwarding inputs: everything masked.
    drive(c1);
    #3;
    chk("rst0.A", int'(fwdSignalA), 0);
    chk("rst0.B", int'(fwdSignalB), 0);
    chk("rst0.C", int'(fwdSignalC), 0);
    chk("rst0.cnt", int'(fwdEventCount), 0);
    @(posedge Clock); #1;
    chk("rst0.cntHeld", int'(fwdEventCount), 0);

    // Mid-cycle release: selects follow immediately, counter waits for the edge.
    #2 Reset_n = 1'b1;
    #1;
    checkSel("rel", c1);
    chk("rel.cnt", int'(fwdEventCount), 0);
    for (int i = 0; i < 3; i++) step("c1run", c1, 1'b1);
    chk("c1run.three", int'(fwdEventCount), 3);

    doReset();
    for (int i = 0; i < 8; i++) step($sformatf("tbl%0d", i), tbl[i], 1'b1);

    // Saturation: 2-bit counter holds at 3 after five forwarding cycles.
    doReset();
    for (int i = 0; i < 5; i++) step("satrun", c1, 1'b0);
    chk("sat.final", int'(satCount), 3);
    chk("sat.wide", int'(fwdEventCount), 5);

    // Asynchronous assert mid-cycle while forwarding.
    drive(c1);
    #1 Reset_n = 1'b0;
    #1;
    chk("async.A", int'(fwdSignalA), 0);
    chk("async.cnt", int'(fwdEventCount), 0);
    refCnt = 0; refSat = 0;
    #1 Reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      v = model(v);
      step("rand", v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
